// File: rtl/vga_fb_scaler_addr_pkg.sv
// ----------------------------------------------------------------------------
// vga_fb_scaler_addr_pkg
//  Shared definitions for the framebuffer read-address generator:
//  scale-mode encodings, default geometry, out-of-window address for the
//  default address width and RGB332 colour constants.
// ----------------------------------------------------------------------------
package vga_fb_scaler_addr_pkg;

    // scale_mode encodings; the two upper codes are reserved and behave as 1x
    typedef enum logic [1:0] {
        SCALE_1X   = 2'b00,
        SCALE_2X   = 2'b01,
        SCALE_RSV2 = 2'b10,
        SCALE_RSV3 = 2'b11
    } scale_e;

    // default geometry
    localparam int CAM_X_DEF = 320;
    localparam int CAM_Y_DEF = 240;
    localparam int VGA_X_DEF = 640;
    localparam int VGA_Y_DEF = 480;
    localparam int AW_DEF    = 17;
    localparam int DW_DEF    = 8;

    // address driven when no frame-buffer pixel is wanted
    localparam logic [AW_DEF-1:0] OOB_ADDR = '1;

    // RGB332 colours
    localparam logic [7:0] COLOR_BLACK = 8'h00;
    localparam logic [7:0] COLOR_RED   = 8'hE0;
    localparam logic [7:0] COLOR_GREEN = 8'h1C;
    localparam logic [7:0] COLOR_BLUE  = 8'h03;
    localparam logic [7:0] COLOR_WHITE = 8'hFF;

    // reserved codes fall back to 1x
    function automatic logic is_scale_2x(input logic [1:0] mode);
        return mode == SCALE_2X;
    endfunction

endpackage

// File: rtl/vga_fb_scaler_addr_window_calc.sv
// ----------------------------------------------------------------------------
// vga_window_calc
//  Combinational image-window geometry from the latched configuration.
//  All four candidate geometries are elaboration-time constants, so the
//  logic reduces to a pair of muxes.
//  Ports:
//    scale_2x   in   1   latched scale (1 = 2x, 0 = 1x)
//    center_en  in   1   latched centring enable
//    off_x      out  12  first window column
//    off_y      out  12  first window row
//    win_w      out  12  window width in VGA pixels
//    win_h      out  12  window height in VGA lines
// ----------------------------------------------------------------------------
module vga_window_calc
    import vga_fb_scaler_addr_pkg::*;
#(
    parameter int CAM_SCREEN_X = CAM_X_DEF,
    parameter int CAM_SCREEN_Y = CAM_Y_DEF,
    parameter int VGA_X        = VGA_X_DEF,
    parameter int VGA_Y        = VGA_Y_DEF
) (
    input  logic        scale_2x,
    input  logic        center_en,
    output logic [11:0] off_x,
    output logic [11:0] off_y,
    output logic [11:0] win_w,
    output logic [11:0] win_h
);

    localparam int W1 = CAM_SCREEN_X;
    localparam int W2 = 2 * CAM_SCREEN_X;
    localparam int H1 = CAM_SCREEN_Y;
    localparam int H2 = 2 * CAM_SCREEN_Y;

    // an image wider/taller than the screen is pinned to the top-left corner
    localparam int OX1 = (VGA_X > W1) ? (VGA_X - W1) / 2 : 0;
    localparam int OX2 = (VGA_X > W2) ? (VGA_X - W2) / 2 : 0;
    localparam int OY1 = (VGA_Y > H1) ? (VGA_Y - H1) / 2 : 0;
    localparam int OY2 = (VGA_Y > H2) ? (VGA_Y - H2) / 2 : 0;

    always_comb begin
        win_w = scale_2x ? 12'(W2) : 12'(W1);
        win_h = scale_2x ? 12'(H2) : 12'(H1);
        off_x = 12'd0;
        off_y = 12'd0;
        if (center_en) begin
            off_x = scale_2x ? 12'(OX2) : 12'(OX1);
            off_y = scale_2x ? 12'(OY2) : 12'(OY1);
        end
    end

endmodule

// File: rtl/vga_fb_scaler_addr.sv
// ----------------------------------------------------------------------------
// vga_fb_scaler_addr
//  Frame-buffer read-address generator and pixel muxer for a 640x480 VGA
//  output. Maps the driver's next-pixel position to a camera-buffer address
//  with 1x/2x integer upscale and optional centring, using incremental
//  counters instead of a multiplier. Pixels outside the image window are
//  painted with border_color. Latency from position to pixel is 3 clocks.
//  Ports:
//    clk           in   1   VGA pixel clock
//    rst           in   1   synchronous active-high reset
//    scale_mode    in   2   00=1x, 01=2x, others=1x (latched at frame boundary)
//    center_en     in   1   centre image (latched at frame boundary)
//    border_color  in   DW  colour outside the image window
//    vga_posX      in   10  next-pixel X (counts through blanking)
//    vga_posY      in   9   next-pixel Y
//    mem_addr      out  AW  registered frame-buffer read address
//    mem_data      in   DW  frame-buffer data, 1 clk after mem_addr
//    pixel_out     out  DW  registered pixel
//    in_window     out  1   pixel_out came from the frame buffer
// ----------------------------------------------------------------------------
module vga_fb_scaler_addr
    import vga_fb_scaler_addr_pkg::*;
#(
    parameter int CAM_SCREEN_X = CAM_X_DEF,
    parameter int CAM_SCREEN_Y = CAM_Y_DEF,
    parameter int VGA_X        = VGA_X_DEF,
    parameter int VGA_Y        = VGA_Y_DEF,
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    scale_mode,
    input  logic          center_en,
    input  logic [DW-1:0] border_color,
    input  logic [9:0]    vga_posX,
    input  logic [8:0]    vga_posY,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] pixel_out,
    output logic          in_window
);

    localparam logic [AW-1:0] ADDR_OOB = {AW{1'b1}};

    // latched configuration and resync state
    logic          mode_2x_reg;
    logic          center_reg;
    logic          synced_reg;

    // address counters
    logic [AW-1:0] row_base_reg;
    logic [AW-1:0] col_reg;
    logic          xsub_reg;
    logic          ysub_reg;

    // pipeline
    logic          win_d1_reg;
    logic          win_d2_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] pixel_out_reg;
    logic          in_window_reg;

    logic [11:0]   off_x, off_y, win_w, win_h;
    logic [11:0]   pos_x, pos_y;
    logic          x_in, y_in, win, line_end, frame_boundary;

    vga_window_calc #(
        .CAM_SCREEN_X (CAM_SCREEN_X),
        .CAM_SCREEN_Y (CAM_SCREEN_Y),
        .VGA_X        (VGA_X),
        .VGA_Y        (VGA_Y)
    ) u_window_calc (
        .scale_2x  (mode_2x_reg),
        .center_en (center_reg),
        .off_x     (off_x),
        .off_y     (off_y),
        .win_w     (win_w),
        .win_h     (win_h)
    );

    always_comb begin
        pos_x          = {2'b00, vga_posX};
        pos_y          = {3'b000, vga_posY};
        x_in           = (pos_x >= off_x) && (pos_x < off_x + win_w) && (pos_x < 12'(VGA_X));
        y_in           = (pos_y >= off_y) && (pos_y < off_y + win_h) && (pos_y < 12'(VGA_Y));
        // nothing is shown until the counters have been aligned to a frame
        win            = synced_reg && x_in && y_in;
        line_end       = synced_reg && (pos_x == 12'(VGA_X)) && y_in;
        frame_boundary = (vga_posX == 10'd0) && (pos_y == 12'(VGA_Y));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_2x_reg   <= 1'b0;
            center_reg    <= 1'b0;
            synced_reg    <= 1'b0;
            row_base_reg  <= '0;
            col_reg       <= '0;
            xsub_reg      <= 1'b0;
            ysub_reg      <= 1'b0;
            win_d1_reg    <= 1'b0;
            win_d2_reg    <= 1'b0;
            mem_addr_reg  <= ADDR_OOB;
            pixel_out_reg <= DW'(COLOR_BLACK);
            in_window_reg <= 1'b0;
        end else begin
            // win travels two stages to line up with the returned mem_data
            win_d1_reg    <= win;
            win_d2_reg    <= win_d1_reg;
            in_window_reg <= win_d2_reg;
            pixel_out_reg <= win_d2_reg ? mem_data : border_color;
            mem_addr_reg  <= win ? (row_base_reg + col_reg) : ADDR_OOB;

            if (frame_boundary) begin
                mode_2x_reg  <= is_scale_2x(scale_mode);
                center_reg   <= center_en;
                synced_reg   <= 1'b1;
                row_base_reg <= '0;
                col_reg      <= '0;
                xsub_reg     <= 1'b0;
                ysub_reg     <= 1'b0;
            end else if (win) begin
                // in 2x each source column is emitted on two consecutive pixels
                if (!mode_2x_reg || xsub_reg) begin
                    col_reg  <= col_reg + AW'(1);
                    xsub_reg <= 1'b0;
                end else begin
                    xsub_reg <= 1'b1;
                end
            end else if (line_end) begin
                col_reg  <= '0;
                xsub_reg <= 1'b0;
                // in 2x each source row is emitted on two consecutive lines
                if (!mode_2x_reg || ysub_reg) begin
                    row_base_reg <= row_base_reg + AW'(CAM_SCREEN_X);
                    ysub_reg     <= 1'b0;
                end else begin
                    ysub_reg <= 1'b1;
                end
            end
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign pixel_out = pixel_out_reg;
    assign in_window = in_window_reg;

endmodule
